// File: rtl/wrr2_req_src_if.sv
// Arbiter request/grant and TX beat signals of wrr2_req_src.
// master = the request source, slave = the arbiter plus the TX datapath side.
interface wrr2_req_src_if;
  logic       req_val;
  logic       req0;
  logic       req1;
  logic [4:0] wt0;
  logic [4:0] wt1;
  logic       gnt_val;
  logic       gnt0;
  logic       gnt1;
  logic       gnt_busy;
  logic       tx_val;
  logic       tx_ch;
  logic       tx_last;
  logic       tx_rdy;

  modport master (
    output req_val, req0, req1, wt0, wt1, gnt_busy, tx_val, tx_ch, tx_last,
    input  gnt_val, gnt0, gnt1, tx_rdy
  );

  modport slave (
    input  req_val, req0, req1, wt0, wt1, gnt_busy, tx_val, tx_ch, tx_last,
    output gnt_val, gnt0, gnt1, tx_rdy
  );
endinterface

// File: rtl/wrr2_req_src.sv
// Request source for the two-input WRR arbiter: pending-packet counters, a
// request/grant FSM and a beat streamer that emits one granted packet as 64 B beats.
module wrr2_req_src #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq0,
  input  logic               enq1,
  input  logic [2:0]         pmtu0,
  input  logic [2:0]         pmtu1,
  wrr2_req_src_if.master     bus,
  output logic [CNT_W-1:0]   pend0,
  output logic [CNT_W-1:0]   pend1,
  output logic [1:0]         err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, XFER} state_t;

  function automatic logic [2:0] clamp_code(input logic [2:0] code);
    return (code > 3'd4) ? 3'd4 : code;
  endfunction

  function automatic logic [4:0] code_weight(input logic [2:0] code);
    logic [4:0] w;
    case (code)
      3'd0:    w = 5'd16;
      3'd1:    w = 5'd8;
      3'd2:    w = 5'd4;
      3'd3:    w = 5'd2;
      default: w = 5'd1;
    endcase
    return w;
  endfunction

  // Index of the final beat, (4 << code) - 1, for a clamped code.
  function automatic logic [5:0] last_beat_idx(input logic [2:0] code);
    logic [5:0] n;
    case (code)
      3'd0:    n = 6'd3;
      3'd1:    n = 6'd7;
      3'd2:    n = 6'd15;
      3'd3:    n = 6'd31;
      default: n = 6'd63;
    endcase
    return n;
  endfunction

  logic [1:0]            enq_v;
  logic [1:0][2:0]       code_c;
  logic [1:0][CNT_W-1:0] pend_w;
  logic [1:0]            pend_nz;
  logic [1:0]            dec;
  logic [1:0]            ovf;

  state_t     state_q, state_d;
  logic [5:0] beat_q, beat_d;
  logic       ch_q, ch_d;
  logic [1:0] err_q, err_d;

  logic grant_legal;
  logic grant_ch;
  logic req_val_c;
  logic tx_val_c;
  logic tx_last_c;

  assign enq_v     = {enq1, enq0};
  assign code_c[0] = clamp_code(pmtu0);
  assign code_c[1] = clamp_code(pmtu1);

  // A grant counts only in WAIT, one-hot, and on a channel that still has work.
  assign grant_ch    = bus.gnt1;
  assign grant_legal = (state_q == WAIT) && bus.gnt_val && (bus.gnt0 ^ bus.gnt1)
                       && pend_nz[grant_ch];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign dec[gi] = grant_legal && (grant_ch == 1'(gi));
      assign ovf[gi] = enq_v[gi] && !dec[gi] && (cnt_q == {CNT_W{1'b1}});

      // Enqueue together with a grant decrement cancels out.
      always_comb begin
        cnt_d = cnt_q;
        if (enq_v[gi] && !dec[gi] && !ovf[gi]) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (dec[gi] && !enq_v[gi]) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pend_w[gi]  = cnt_q;
      assign pend_nz[gi] = |cnt_q;
    end
  endgenerate

  // Any grant that is not legal in WAIT is flagged, whatever the state.
  assign err_d = err_q | {bus.gnt_val && !grant_legal, |ovf};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ch_d      = ch_q;
    req_val_c = 1'b0;
    tx_val_c  = 1'b0;
    tx_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_nz) begin
          state_d = REQ;
        end
      end
      REQ: begin
        req_val_c = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.gnt_val) begin
          if (grant_legal) begin
            ch_d    = grant_ch;
            beat_d  = last_beat_idx(code_c[grant_ch]);
            state_d = XFER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      XFER: begin
        tx_val_c  = 1'b1;
        tx_last_c = (beat_q == 6'd0);
        if (bus.tx_rdy) begin
          if (beat_q == 6'd0) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q - 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ch_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_val  = req_val_c;
  assign bus.req0     = req_val_c & pend_nz[0];
  assign bus.req1     = req_val_c & pend_nz[1];
  assign bus.wt0      = code_weight(code_c[0]);
  assign bus.wt1      = code_weight(code_c[1]);
  assign bus.gnt_busy = tx_val_c;
  assign bus.tx_val   = tx_val_c;
  assign bus.tx_ch    = tx_val_c & ch_q;
  assign bus.tx_last  = tx_last_c;

  assign pend0 = pend_w[0];
  assign pend1 = pend_w[1];
  assign err   = err_q;

endmodule

// File: tb/tb_wrr2_req_src.sv
// Randomised bench for wrr2_req_src: a packet-level model predicts counts, errors
// and beat sequences; a negedge monitor compares them against the DUT.
module tb_wrr2_req_src;
  localparam int CNT_W = 8;
  localparam int MAXC  = 255;

  typedef struct {
    bit ch;
    bit last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enq0 = 1'b0;
  logic             enq1 = 1'b0;
  logic [2:0]       pmtu0 = 3'd0;
  logic [2:0]       pmtu1 = 3'd0;
  logic [CNT_W-1:0] pend0, pend1;
  logic [1:0]       err;

  wrr2_req_src_if bus ();

  wrr2_req_src #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .enq0  (enq0),
    .enq1  (enq1),
    .pmtu0 (pmtu0),
    .pmtu1 (pmtu1),
    .bus   (bus.master),
    .pend0 (pend0),
    .pend1 (pend1),
    .err   (err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    m_pend [2];
  bit [1:0] m_err = 2'b00;
  beat_t exp_q[$];
  bit    g_in_wait = 1'b0;
  bit    mon_en = 1'b0;

  function automatic int clampc(input int c);
    return (c > 4) ? 4 : c;
  endfunction

  function automatic int weight_of(input int c);
    return 4096 / (256 << clampc(c));
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Packet-level model, evaluated on the edge that samples the inputs.
  task automatic model_update();
    bit [1:0] dec;
    bit [1:0] e;
    int       ch;
    int       n;
    dec = 2'b00;
    e   = {enq1, enq0};
    if (rst) begin
      m_pend[0] = 0;
      m_pend[1] = 0;
      m_err     = 2'b00;
      exp_q.delete();
    end else begin
      if (bus.gnt_val) begin
        if (g_in_wait && (bus.gnt0 != bus.gnt1) && m_pend[int'(bus.gnt1)] != 0) begin
          ch      = int'(bus.gnt1);
          dec[ch] = 1'b1;
          n       = (256 << clampc(ch ? int'(pmtu1) : int'(pmtu0))) / 64;
          for (int k = 0; k < n; k++) exp_q.push_back('{ch: ch[0], last: (k == n - 1)});
        end else begin
          m_err[1] = 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (e[i] && !dec[i]) begin
          if (m_pend[i] == MAXC) m_err[0] = 1'b1;
          else m_pend[i]++;
        end else if (dec[i] && !e[i]) begin
          m_pend[i]--;
        end
      end
    end
  endtask

  // One clock: model sees the sampled inputs, then pulses are dropped.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    enq0        = 1'b0;
    enq1        = 1'b0;
    bus.gnt_val = 1'b0;
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    g_in_wait   = 1'b0;
  endtask

  task automatic rand_inputs();
    enq0 = ($urandom_range(0, 3) == 0);
    enq1 = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 7) == 0) pmtu0 = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) pmtu1 = 3'($urandom_range(0, 7));
    bus.tx_rdy = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      if (m_pend[0] == 0 && m_pend[1] == 0 && !enq0 && !enq1) enq0 = 1'b1;
      tick();
      if (bus.req_val) begin
        ok = 1'b1;
        return;
      end
    end
    chk("req_timeout", 0, 1);
  endtask

  // Called in the REQ cycle; grants during the following WAIT.
  task automatic do_grant(input bit g0, input bit g1, input bit rnd);
    tick();
    if (rnd) begin
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        rand_inputs();
        tick();
      end
      rand_inputs();
    end
    bus.gnt_val = 1'b1;
    bus.gnt0    = g0;
    bus.gnt1    = g1;
    g_in_wait   = 1'b1;
    tick();
  endtask

  task automatic drain(input bit rnd, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      if (rnd) begin
        rand_inputs();
        if ($urandom_range(0, 19) == 0) begin
          bus.gnt_val = 1'b1;
          bus.gnt0    = $urandom_range(0, 1);
          bus.gnt1    = $urandom_range(0, 1);
        end
      end
      tick();
      n++;
    end
    if (n >= 2000) begin
      chk("drain_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  // Monitor: steady-state values every cycle, requests and beats when presented.
  bit prev_stall = 1'b0;
  bit prev_ch    = 1'b0;
  bit prev_last  = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (mon_en) begin
      chk("pend0", int'(pend0), m_pend[0]);
      chk("pend1", int'(pend1), m_pend[1]);
      chk("err", int'(err), int'(m_err));
      chk("wt0", int'(bus.wt0), weight_of(int'(pmtu0)));
      chk("wt1", int'(bus.wt1), weight_of(int'(pmtu1)));
      chk("busy_vs_txval", int'(bus.gnt_busy), int'(bus.tx_val));
      if (bus.req_val) begin
        chk("req0", int'(bus.req0), int'(m_pend[0] != 0));
        chk("req1", int'(bus.req1), int'(m_pend[1] != 0));
      end
      if (prev_stall) begin
        chk("stall_val", int'(bus.tx_val), 1);
        chk("stall_ch", int'(bus.tx_ch), int'(prev_ch));
        chk("stall_last", int'(bus.tx_last), int'(prev_last));
      end
      if (bus.tx_val && bus.tx_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_ch", int'(bus.tx_ch), int'(b.ch));
          chk("beat_last", int'(bus.tx_last), int'(b.last));
        end
      end
      prev_stall = bus.tx_val && !bus.tx_rdy && !rst;
      prev_ch    = bus.tx_ch;
      prev_last  = bus.tx_last;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_val"}, int'(bus.req_val), 0);
    chk({tag, "_req0"}, int'(bus.req0), 0);
    chk({tag, "_req1"}, int'(bus.req1), 0);
    chk({tag, "_busy"}, int'(bus.gnt_busy), 0);
    chk({tag, "_tx_val"}, int'(bus.tx_val), 0);
    chk({tag, "_tx_ch"}, int'(bus.tx_ch), 0);
    chk({tag, "_tx_last"}, int'(bus.tx_last), 0);
    chk({tag, "_pend0"}, int'(pend0), 0);
    chk({tag, "_pend1"}, int'(pend1), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    bit ok;
    int n;
    bit g0, g1;
    m_pend[0]   = 0;
    m_pend[1]   = 0;
    bus.gnt_val = 1'b0;
    bus.gnt0    = 1'b0;
    bus.gnt1    = 1'b0;
    bus.tx_rdy  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_wt0", int'(bus.wt0), 16);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single enqueue: request two cycles later, then a 16-beat packet
    pmtu0 = 3'd2;
    enq0  = 1'b1;
    tick();
    chk("lat_t1_req_val", int'(bus.req_val), 0);
    tick();
    chk("lat_t2_req_val", int'(bus.req_val), 1);
    chk("lat_req0", int'(bus.req0), 1);
    chk("lat_req1", int'(bus.req1), 0);
    chk("lat_wt0", int'(bus.wt0), 4);
    bus.tx_rdy = 1'b1;
    do_grant(1'b1, 1'b0, 1'b0);
    drain(1'b0, n);
    chk("lat_xfer_cycles", n, 16);
    chk("lat_busy_after", int'(bus.gnt_busy), 0);
    chk("lat_pend0_after", int'(pend0), 0);

    // Randomised rounds: weighted grants, illegal grants, stray grants, back-pressure
    for (int r = 0; r < 60; r++) begin
      int p;
      wait_req(ok);
      if (!ok) break;
      p = $urandom_range(0, 9);
      if (p == 0) begin
        g0 = 1'b1; g1 = 1'b1;
      end else if (p == 1) begin
        g0 = 1'b0; g1 = 1'b0;
      end else if (bus.req0 && bus.req1) begin
        g1 = ($urandom_range(1, int'(bus.wt0) + int'(bus.wt1)) > int'(bus.wt0));
        g0 = !g1;
      end else begin
        g1 = bus.req1;
        g0 = !bus.req1;
      end
      do_grant(g0, g1, 1'b1);
      drain(1'b1, n);
    end

    // Reset during beat 5 of a 64-beat packet
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    pmtu0      = 3'd4;
    bus.tx_rdy = 1'b1;
    enq0       = 1'b1;
    tick();
    tick();
    chk("abort_req_val", int'(bus.req_val), 1);
    do_grant(1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chk("abort_beats_left", exp_q.size(), 60);
    rst = 1'b1;
    tick();
    chk_all_zero("abort");
    rst = 1'b0;

    // Saturation on channel 1, then enqueue plus grant in the same cycle
    pmtu1 = 3'd1;
    for (int i = 0; i < 256; i++) begin
      enq1 = 1'b1;
      tick();
    end
    chk("sat_pend1", int'(pend1), 255);
    chk("sat_err0", int'(err[0]), 1);
    enq1        = 1'b1;
    bus.gnt_val = 1'b1;
    bus.gnt1    = 1'b1;
    g_in_wait   = 1'b1;
    tick();
    chk("sat_enq_gnt_pend1", int'(pend1), 255);
    drain(1'b0, n);
    chk("sat_xfer_cycles", n, 8);
    chk("sat_pend1_end", int'(pend1), 255);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout got 1 expected 0");
    $fatal(1, "watchdog");
  end

endmodule
